// File: rtl/stream_ram_writer_pkg.sv
// rtl/stream_ram_writer_pkg.sv - shared FSM state encoding for stream_ram_writer
package stream_ram_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/ram_sdp.sv
// rtl/ram_sdp.sv - simple dual-port RAM, one write port and one registered read port
module ram_sdp #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int MEMORY_DEPTH  = 2**ADDRESS_WIDTH
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_W = (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  // Read samples the array before this edge's write lands, giving old data on a collision.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = ({1'b0, rd_addr} < DEPTH_W) ? mem[rd_addr[IDX_W-1:0]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/stream_ram_writer.sv
// rtl/stream_ram_writer.sv - burst writer that streams Data_i into a RAM from a start address
module stream_ram_writer
  import stream_ram_writer_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8,
  parameter int MEMORY_DEPTH  = 2**ADDRESS_WIDTH
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start_i,
  input  logic [ADDRESS_WIDTH-1:0] StartAddress_i,
  input  logic [ADDRESS_WIDTH-1:0] Length_i,
  input  logic [DATA_WIDTH-1:0]    Data_i,
  input  logic                     Valid_i,
  output logic                     Ready_o,
  output logic                     Busy_o,
  output logic                     Done_o,
  input  logic                     ReadEnable_i,
  input  logic [ADDRESS_WIDTH-1:0] ReadAddress_i,
  output logic [DATA_WIDTH-1:0]    ReadData_o
);

  if (MEMORY_DEPTH > 2**ADDRESS_WIDTH) begin : g_depth_check
    $fatal(1, "MEMORY_DEPTH exceeds 2**ADDRESS_WIDTH");
  end

  localparam logic [ADDRESS_WIDTH:0]   DEPTH_W   = (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] ONE       = ADDRESS_WIDTH'(1);

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic                     xfer;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    xfer    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Start_i) begin
          ptr_d   = ({1'b0, StartAddress_i} < DEPTH_W) ? StartAddress_i : '0;
          cnt_d   = Length_i;
          state_d = (Length_i != '0) ? ST_WRITE : ST_DONE;
        end
      end
      ST_WRITE: begin
        if (Valid_i) begin
          xfer  = 1'b1;
          ptr_d = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ONE;
          cnt_d = cnt_q - ONE;
          if (cnt_q == ONE) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Ready_o = (state_q == ST_WRITE);
  assign Busy_o  = (state_q != ST_IDLE);
  assign Done_o  = (state_q == ST_DONE);

  // A word presented during a reset cycle must not reach the array.
  ram_sdp #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .MEMORY_DEPTH (MEMORY_DEPTH)
  ) u_ram (
    .clk    (Clock),
    .resetn (Reset),
    .wr_en  (xfer & Reset),
    .wr_addr(ptr_q),
    .wr_data(Data_i),
    .rd_en  (ReadEnable_i),
    .rd_addr(ReadAddress_i),
    .rd_data(ReadData_o)
  );

endmodule

// File: tb/tb_stream_ram_writer.sv
// tb/tb_stream_ram_writer.sv - directed self-checking bench for stream_ram_writer
module tb_stream_ram_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rstn, a_start, a_valid, a_ready, a_busy, a_done, a_ren;
  logic [15:0] a_saddr, a_len, a_raddr;
  logic [7:0]  a_data, a_rdata;

  logic        b_rstn, b_start, b_valid, b_ready, b_busy, b_done, b_ren;
  logic [7:0]  b_saddr, b_len, b_raddr;
  logic [7:0]  b_data, b_rdata;

  int checks = 0;
  int errors = 0;

  stream_ram_writer dut_a (
    .Clock(clk), .Reset(a_rstn), .Start_i(a_start), .StartAddress_i(a_saddr),
    .Length_i(a_len), .Data_i(a_data), .Valid_i(a_valid), .Ready_o(a_ready),
    .Busy_o(a_busy), .Done_o(a_done), .ReadEnable_i(a_ren),
    .ReadAddress_i(a_raddr), .ReadData_o(a_rdata)
  );

  stream_ram_writer #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8), .MEMORY_DEPTH(16)) dut_b (
    .Clock(clk), .Reset(b_rstn), .Start_i(b_start), .StartAddress_i(b_saddr),
    .Length_i(b_len), .Data_i(b_data), .Valid_i(b_valid), .Ready_o(b_ready),
    .Busy_o(b_busy), .Done_o(b_done), .ReadEnable_i(b_ren),
    .ReadAddress_i(b_raddr), .ReadData_o(b_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_a(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    a_ren = 1'b1;
    a_raddr = addr;
    tick();
    a_ren = 1'b0;
    check(tag, 32'(a_rdata), 32'(exp));
  endtask

  task automatic read_b(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    b_ren = 1'b1;
    b_raddr = addr;
    tick();
    b_ren = 1'b0;
    check(tag, 32'(b_rdata), 32'(exp));
  endtask

  task automatic write1_a(input logic [15:0] addr, input logic [7:0] d);
    a_start = 1'b1; a_saddr = addr; a_len = 16'd1;
    tick();
    a_start = 1'b0; a_valid = 1'b1; a_data = d;
    tick();
    a_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    a_rstn = 1'b0; a_start = 1'b0; a_valid = 1'b0; a_ren = 1'b0;
    a_saddr = '0; a_len = '0; a_raddr = '0; a_data = '0;
    b_rstn = 1'b0; b_start = 1'b0; b_valid = 1'b0; b_ren = 1'b0;
    b_saddr = '0; b_len = '0; b_raddr = '0; b_data = '0;
    tick();
    tick();

    check("reset_ready", 32'(a_ready), 32'd0);
    check("reset_busy",  32'(a_busy),  32'd0);
    check("reset_done",  32'(a_done),  32'd0);
    check("reset_rdata", 32'(a_rdata), 32'd0);
    a_rstn = 1'b1;
    b_rstn = 1'b1;
    tick();

    write1_a(16'h0020, 8'h00);
    write1_a(16'h0042, 8'h77);
    write1_a(16'h0033, 8'h55);

    // Four-word burst with Valid held high
    a_start = 1'b1; a_saddr = 16'h0010; a_len = 16'd4;
    tick();
    a_start = 1'b0;
    check("b4_busy", 32'(a_busy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("b4_ready", 32'(a_ready), 32'd1);
      a_valid = 1'b1;
      a_data = 8'hA1 + 8'(i);
      tick();
    end
    a_valid = 1'b0;
    check("b4_ready_off", 32'(a_ready), 32'd0);
    check("b4_done", 32'(a_done), 32'd1);
    tick();
    check("b4_done_pulse", 32'(a_done), 32'd0);
    check("b4_idle", 32'(a_busy), 32'd0);
    read_a("b4_rd10", 16'h0010, 8'hA1);
    read_a("b4_rd11", 16'h0011, 8'hA2);
    read_a("b4_rd12", 16'h0012, 8'hA3);
    read_a("b4_rd13", 16'h0013, 8'hA4);
    a_raddr = 16'h0010;
    tick();
    check("rd_hold", 32'(a_rdata), 32'hA4);

    // Length 3 with Valid toggling 0/1, garbage on idle cycles
    a_start = 1'b1; a_saddr = 16'h0030; a_len = 16'd3;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("tog_ready", 32'(a_ready), 32'd1);
      a_valid = c[0];
      a_data = c[0] ? (8'hB1 + 8'(c / 2)) : 8'hEE;
      tick();
    end
    a_valid = 1'b0;
    check("tog_done", 32'(a_done), 32'd1);
    tick();
    read_a("tog_rd30", 16'h0030, 8'hB1);
    read_a("tog_rd31", 16'h0031, 8'hB2);
    read_a("tog_rd32", 16'h0032, 8'hB3);
    read_a("tog_rd33", 16'h0033, 8'h55);

    // Empty burst
    a_start = 1'b1; a_saddr = 16'h0010; a_len = 16'd0;
    tick();
    a_start = 1'b0;
    check("len0_ready", 32'(a_ready), 32'd0);
    check("len0_done", 32'(a_done), 32'd1);
    tick();
    check("len0_done_pulse", 32'(a_done), 32'd0);

    // Start accepted in the IDLE cycle right after DONE, then reset mid-burst
    a_start = 1'b1; a_saddr = 16'h0040; a_len = 16'd5;
    tick();
    a_start = 1'b0;
    check("rst_ready", 32'(a_ready), 32'd1);
    a_valid = 1'b1; a_data = 8'hC1;
    tick();
    a_data = 8'hC2;
    tick();
    a_data = 8'hC3;
    a_rstn = 1'b0;
    tick();
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_ready_off", 32'(a_ready), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    a_rstn = 1'b1;
    a_valid = 1'b0;
    tick();
    check("rst_no_done", 32'(a_done), 32'd0);
    read_a("len0_rd10", 16'h0010, 8'hA1);
    read_a("rst_rd40", 16'h0040, 8'hC1);
    read_a("rst_rd41", 16'h0041, 8'hC2);
    read_a("rst_rd42", 16'h0042, 8'h77);

    // Same-address read/write collision
    a_start = 1'b1; a_saddr = 16'h0020; a_len = 16'd1;
    tick();
    a_start = 1'b0;
    a_valid = 1'b1; a_data = 8'h5A;
    a_ren = 1'b1; a_raddr = 16'h0020;
    tick();
    a_valid = 1'b0;
    check("coll_old", 32'(a_rdata), 32'h00);
    check("coll_done", 32'(a_done), 32'd1);
    tick();
    a_ren = 1'b0;
    check("coll_new", 32'(a_rdata), 32'h5A);

    // Wrap in a 16-word memory
    b_start = 1'b1; b_saddr = 8'h0E; b_len = 8'd4;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_valid = 1'b1;
      b_data = 8'h11 * 8'(i + 1);
      tick();
    end
    b_valid = 1'b0;
    check("wrap_done", 32'(b_done), 32'd1);
    tick();
    read_b("wrap_rd0e", 8'h0E, 8'h11);
    read_b("wrap_rd0f", 8'h0F, 8'h22);
    read_b("wrap_rd00", 8'h00, 8'h33);
    read_b("wrap_rd01", 8'h01, 8'h44);
    read_b("oor_rd20", 8'h20, 8'h00);

    // Out-of-range start address reduces to 0
    b_start = 1'b1; b_saddr = 8'h20; b_len = 8'd1;
    tick();
    b_start = 1'b0;
    b_valid = 1'b1; b_data = 8'h99;
    tick();
    b_valid = 1'b0;
    tick();
    read_b("oor_start_rd00", 8'h00, 8'h99);
    read_b("oor_start_rd01", 8'h01, 8'h44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_ram_writer.md
STREAM_RAM_WRITER -- requirements
Module: stream_ram_writer

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 16, address bits of write and read ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per memory word.
REQ-003 SHALL have parameter MEMORY_DEPTH, default 2**ADDRESS_WIDTH, number of words; values > 2**ADDRESS_WIDTH SHALL stop elaboration with $fatal.
REQ-004 SHALL have port Clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port Start_i  input  1  burst start request.
REQ-007 SHALL have port StartAddress_i  input  ADDRESS_WIDTH  first write address.
REQ-008 SHALL have port Length_i  input  ADDRESS_WIDTH  number of words in burst; 0 = empty burst.
REQ-009 SHALL have port Data_i  input  DATA_WIDTH  write stream data.
REQ-010 SHALL have port Valid_i  input  1  Data_i valid.
REQ-011 SHALL have port Ready_o  output  1  writer accepts Data_i.
REQ-012 SHALL have port Busy_o  output  1  burst in progress.
REQ-013 SHALL have port Done_o  output  1  one-cycle burst-complete pulse.
REQ-014 SHALL have port ReadEnable_i  input  1  read strobe.
REQ-015 SHALL have port ReadAddress_i  input  ADDRESS_WIDTH  read address.
REQ-016 SHALL have port ReadData_o  output  DATA_WIDTH  registered read data.

Function
REQ-017 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-018 IDLE: Start_i=1 SHALL latch StartAddress_i as write pointer and Length_i as remaining count; next state WRITE if Length_i!=0, else DONE.
REQ-019 Start_i SHALL be ignored in WRITE and DONE.
REQ-020 Ready_o SHALL be 1 exactly while in WRITE; Busy_o SHALL be 1 in WRITE and DONE.
REQ-021 A transfer SHALL occur on a cycle with Valid_i=1 and Ready_o=1: Memory[pointer] <= Data_i, pointer increments, count decrements.
REQ-022 Valid_i=0 in WRITE SHALL stall with no memory write and no pointer/count change, indefinitely.
REQ-023 Pointer SHALL wrap from MEMORY_DEPTH-1 to 0 (also when MEMORY_DEPTH < 2**ADDRESS_WIDTH); latched start address >= MEMORY_DEPTH SHALL be reduced to 0 at latch.
REQ-024 Transfer with count==1 SHALL move to DONE; no further word accepted in that burst.
REQ-025 DONE SHALL last exactly one cycle with Done_o=1, then return to IDLE; Start_i in the IDLE cycle right after SHALL be accepted.
REQ-026 Read port SHALL be independent of FSM: ReadEnable_i=1 registers Memory[ReadAddress_i] to ReadData_o on the next edge (1-cycle latency); ReadEnable_i=0 holds ReadData_o.
REQ-027 Read and write to same address in same cycle SHALL return old (pre-write) data.
REQ-028 Read address >= MEMORY_DEPTH SHALL return 0.

Reset
REQ-029 Reset=0 at a rising edge SHALL force IDLE, Ready_o=0, Busy_o=0, Done_o=0, ReadData_o=0, pointer=0, count=0.
REQ-030 Reset SHALL NOT clear memory contents; a transfer presented in a reset cycle SHALL NOT be written.
REQ-031 Reset mid-burst SHALL abandon the burst without Done_o; words already written remain.

Structure
REQ-032 State encodings (IDLE=0, WRITE=1, DONE=2) SHALL live in a shared package/header, not local literals.
REQ-033 Memory array plus read register SHALL be a sub-module ram_sdp (simple dual-port, one write, one registered read port, same parameters); FSM, pointer and counter stay in stream_ram_writer.

Verification
REQ-034 Start at 0x0010, Length 4, Valid held 1 with data A1..A4 -> Ready_o 4 cycles, Done_o one cycle after 4th transfer, reads of 0x10..0x13 return A1..A4.
REQ-035 Length 3, Valid toggling 1/0 each cycle -> exactly 3 writes, Done_o 6 cycles after first Ready_o, no duplicated/skipped word.
REQ-036 MEMORY_DEPTH=16, AW=8, start 0x0E, Length 4, data 11..44 -> writes at 0x0E,0x0F,0x00,0x01.
REQ-037 Start with Length 0 -> no Ready_o, Done_o on second cycle after Start_i, memory unchanged.
REQ-038 Reset low after 2 of 5 words -> Busy_o/Ready_o 0 next cycle, no Done_o, first 2 words readable, 3rd address unchanged.
REQ-039 Write 0x5A to 0x20 while reading 0x20 (old 0x00) -> ReadData_o 0x00, next read 0x5A.
